// File: rtl/snake_pkg.sv
// snake_pkg: grid geometry, direction/state encodings and constants
// shared by the Snake renderer and its LFSR.
package snake_pkg;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;
    localparam int FRAME_ROW  = 480;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [11:0] OVER_COLOR = 12'hF00;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0] col;
        logic [4:0] row;
    } cell_t;

    // Opposite directions differ only in bit 1 of the encoding.
    function automatic dir_t dir_rev(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/snake_lfsr16.sv
// snake_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11)
// used to place food; advances every clock.
module snake_lfsr16
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/snake_pixel_gen.sv
// snake_pixel_gen: Snake game state on a 40x30 grid plus registered RGB render.
// Define SNAKE_WRAP_EN to wrap the head across walls instead of dying.
module snake_pixel_gen
    import snake_pkg::*;
#(
    parameter int          MAX_LEN     = 16,
    parameter int          MOVE_FRAMES = 8,
    parameter logic [11:0] HEAD_COLOR  = 12'h0F0,
    parameter logic [11:0] BODY_COLOR  = 12'h0A0,
    parameter logic [11:0] FOOD_COLOR  = 12'hF00,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [1:0]  dir,
    input  logic        dir_valid,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic [7:0]  score,
    output logic        game_over
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

    state_t             state_q, state_d;
    dir_t               cur_dir, pend_dir, req_dir;
    cell_t              seg [MAX_LEN];
    cell_t              food, nhead, lfsr_cell, pix_cell;
    logic [LEN_W-1:0]   len_q;
    logic [7:0]         score_q;
    logic [CNT_W-1:0]   move_cnt;
    logic [11:0]        rgb_q, pix_d;
    logic [15:0]        lfsr_q;
    logic               lfsr_unused;
    logic signed [6:0]  nx, ny;
    logic               wall_hit, self_hit, eat, collide;
    logic               move_wrap, step_en, dir_ok;
    logic               head_hit, body_hit, food_hit;

    snake_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:11];

    assign frame_tick = p_tick && (x == 10'd0) && (y == 10'(FRAME_ROW));
    assign req_dir    = dir_t'(dir);
    assign dir_ok     = dir_valid && (state_q != ST_OVER)
                        && (req_dir != dir_rev(cur_dir));
    assign move_wrap  = (move_cnt == CNT_W'(MOVE_FRAMES - 1));
    assign step_en    = (state_q == ST_RUN) && frame_tick && move_wrap;

    // Candidate head in signed form so a step off the grid reads as -1/40/30.
    always_comb begin
        nx = $signed({1'b0, seg[0].col});
        ny = $signed({2'b00, seg[0].row});
        unique case (1'b1)
            (pend_dir == DIR_UP):    ny = ny - 7'sd1;
            (pend_dir == DIR_RIGHT): nx = nx + 7'sd1;
            (pend_dir == DIR_DOWN):  ny = ny + 7'sd1;
            default:                 nx = nx - 7'sd1;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_hit = 1'b0;

    always_comb begin
        nhead.col = nx[5:0];
        nhead.row = ny[4:0];
        if (nx < 7'sd0) begin
            nhead.col = 6'(GRID_W - 1);
        end else if (nx > 7'(GRID_W - 1)) begin
            nhead.col = 6'd0;
        end
        if (ny < 7'sd0) begin
            nhead.row = 5'(GRID_H - 1);
        end else if (ny > 7'(GRID_H - 1)) begin
            nhead.row = 5'd0;
        end
    end
`else
    assign wall_hit = (nx < 7'sd0) || (nx > 7'(GRID_W - 1))
                      || (ny < 7'sd0) || (ny > 7'(GRID_H - 1));
    assign nhead    = {nx[5:0], ny[4:0]};
`endif

    assign eat = (nhead == food);

    // The tail only blocks the head when eating keeps it in place.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((LEN_W'(i + 1) < len_q) || (eat && LEN_W'(i + 1) == len_q))
                && (seg[i] == nhead)) begin
                self_hit = 1'b1;
            end
        end
    end

    assign collide = wall_hit || self_hit;

    always_comb begin
        lfsr_cell.col = (lfsr_q[5:0] >= 6'd40) ? lfsr_q[5:0] - 6'd32
                                               : lfsr_q[5:0];
        lfsr_cell.row = (lfsr_q[10:6] >= 5'd30) ? lfsr_q[10:6] - 5'd16
                                                : lfsr_q[10:6];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (dir_valid) state_d = ST_RUN;
            ST_RUN:  if (step_en && collide) state_d = ST_OVER;
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            food     <= '{col: 6'd30, row: 5'd15};
            score_q  <= '0;
            move_cnt <= '0;
            len_q    <= LEN_W'(3);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i] <= '0;
            end
            seg[0] <= '{col: 6'd20, row: 5'd15};
            seg[1] <= '{col: 6'd19, row: 5'd15};
            seg[2] <= '{col: 6'd18, row: 5'd15};
        end else begin
            if (dir_ok) begin
                pend_dir <= req_dir;
            end
            if (state_q == ST_RUN && frame_tick) begin
                move_cnt <= move_wrap ? '0 : move_cnt + 1'b1;
            end
            if (step_en && !collide) begin
                cur_dir <= pend_dir;
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg[i] <= seg[i-1];
                end
                seg[0] <= nhead;
                if (eat) begin
                    if (len_q != LEN_W'(MAX_LEN)) len_q <= len_q + 1'b1;
                    if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                    food <= lfsr_cell;
                end
            end
        end
    end

    assign pix_cell = {x[9:4], y[8:4]};

    always_comb begin
        head_hit = (seg[0] == pix_cell);
        food_hit = (food == pix_cell);
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len_q) && (seg[i] == pix_cell)) begin
                body_hit = 1'b1;
            end
        end
    end

    always_comb begin
        pix_d = BG_COLOR;
        if (!video_on) begin
            pix_d = 12'h000;
        end else if (head_hit) begin
            pix_d = (state_q == ST_OVER) ? OVER_COLOR : HEAD_COLOR;
        end else if (body_hit) begin
            pix_d = (state_q == ST_OVER) ? OVER_COLOR : BODY_COLOR;
        end else if (food_hit) begin
            pix_d = FOOD_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
        end else if (p_tick) begin
            rgb_q <= pix_d;
        end
    end

    assign rgb       = rgb_q;
    assign score     = score_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_snake_pixel_gen.sv
// tb_snake_pixel_gen: directed game scenarios plus a food-seeking random player,
// every cycle compared against a queue-based game model.
module tb_snake_pixel_gen;

    localparam int          ML = 6;
    localparam int          MF = 3;
    localparam logic [11:0] HC = 12'h0F0;
    localparam logic [11:0] BC = 12'h0A0;
    localparam logic [11:0] FC = 12'hF00;
    localparam logic [11:0] BG = 12'h000;
    localparam logic [11:0] OC = 12'hF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [1:0]  dir = '0;
    logic        dir_valid = 1'b0;
    logic [11:0] rgb;
    logic        frame_tick;
    logic [7:0]  score;
    logic        game_over;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snake_pixel_gen #(
        .MAX_LEN     (ML),
        .MOVE_FRAMES (MF),
        .HEAD_COLOR  (HC),
        .BODY_COLOR  (BC),
        .FOOD_COLOR  (FC),
        .BG_COLOR    (BG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .dir        (dir),
        .dir_valid  (dir_valid),
        .rgb        (rgb),
        .frame_tick (frame_tick),
        .score      (score),
        .game_over  (game_over)
    );

    // Game model: snake as coordinate queues, head at the front.
    int          m_sx[$];
    int          m_sy[$];
    int          m_fx, m_fy, m_score, m_cnt, m_dir, m_pend, m_state;
    logic [15:0] m_lfsr;
    logic [11:0] m_rgb;
    bit          m_valid = 0;

    function automatic logic [11:0] pix_color(input bit von, input int px, input int py);
        int cx, cy;
        bit over;
        if (!von) return 12'h000;
        cx = px >> 4;
        cy = (py >> 4) & 31;
        over = (m_state == 2);
        if (m_sx[0] == cx && m_sy[0] == cy) return over ? OC : HC;
        for (int i = 1; i < m_sx.size(); i++)
            if (m_sx[i] == cx && m_sy[i] == cy) return over ? OC : BC;
        if (m_fx == cx && m_fy == cy) return FC;
        return BG;
    endfunction

    always @(posedge clk) begin : model
        int nx, ny, len, opend, odir;
        bit eat, hit, ft;
        logic [15:0] l0;
        if (reset) begin
            m_sx = '{20, 19, 18};
            m_sy = '{15, 15, 15};
            m_fx = 30; m_fy = 15;
            m_score = 0; m_cnt = 0;
            m_dir = 1; m_pend = 1; m_state = 0;
            m_lfsr = 16'hACE1;
            m_rgb = 12'h000;
            m_valid = 1;
        end else if (m_valid) begin
            if (p_tick) m_rgb = pix_color(video_on, int'(x), int'(y));
            ft = p_tick && x == 0 && y == 480;
            l0 = m_lfsr;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            opend = m_pend;
            odir = m_dir;
            if (m_state == 0) begin
                if (dir_valid) begin
                    if (int'(dir) != (odir ^ 2)) m_pend = int'(dir);
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (dir_valid && int'(dir) != (odir ^ 2)) m_pend = int'(dir);
                if (ft) begin
                    if (m_cnt == MF - 1) begin
                        m_cnt = 0;
                        nx = m_sx[0] + (opend == 1 ? 1 : 0) - (opend == 3 ? 1 : 0);
                        ny = m_sy[0] + (opend == 2 ? 1 : 0) - (opend == 0 ? 1 : 0);
`ifdef SNAKE_WRAP_EN
                        nx = (nx + 40) % 40;
                        ny = (ny + 30) % 30;
                        hit = 0;
`else
                        hit = nx < 0 || nx >= 40 || ny < 0 || ny >= 30;
`endif
                        eat = (nx == m_fx && ny == m_fy);
                        len = m_sx.size();
                        for (int i = 0; i < len; i++)
                            if ((i <= len - 2 || eat) && m_sx[i] == nx && m_sy[i] == ny)
                                hit = 1;
                        if (hit) begin
                            m_state = 2;
                        end else begin
                            m_sx.push_front(nx);
                            m_sy.push_front(ny);
                            if (!eat || len == ML) begin
                                void'(m_sx.pop_back());
                                void'(m_sy.pop_back());
                            end
                            if (eat) begin
                                if (m_score < 255) m_score++;
                                m_fx = int'(l0[5:0]);
                                if (m_fx >= 40) m_fx -= 32;
                                m_fy = int'(l0[10:6]);
                                if (m_fy >= 30) m_fy -= 16;
                            end
                            m_dir = opend;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare mid-cycle, then release strobes just after the edge.
    task automatic tick();
        @(negedge clk);
        if (m_valid) begin
            check("rgb", int'(rgb), int'(m_rgb));
            check("score", int'(score), m_score);
            check("game_over", int'(game_over), (m_state == 2) ? 1 : 0);
            check("frame_tick", int'(frame_tick),
                  (p_tick && x == 0 && y == 480) ? 1 : 0);
        end
        @(posedge clk);
        #2;
        p_tick = 1'b0;
        dir_valid = 1'b0;
    endtask

    task automatic rand_pix(input int n);
        for (int k = 0; k < n; k++) begin
            int cx, cy;
            p_tick = ($urandom % 4) != 0;
            video_on = ($urandom % 5) != 0;
            if ($urandom % 2) begin
                cx = m_sx[0] + int'($urandom_range(0, 6)) - 3;
                cy = m_sy[0] + int'($urandom_range(0, 6)) - 3;
            end else begin
                cx = int'($urandom % 40);
                cy = int'($urandom % 30);
            end
            if (cx < 0) cx = 0;
            if (cx > 39) cx = 39;
            if (cy < 0) cy = 0;
            if (cy > 29) cy = 29;
            x = 10'(cx * 16 + int'($urandom % 16));
            y = 10'(cy * 16 + int'($urandom % 16));
            if (!video_on && ($urandom % 2)) x = 10'(640 + int'($urandom % 160));
            tick();
        end
    endtask

    task automatic frame();
        p_tick = 1'b1;
        video_on = 1'b0;
        x = 10'd0;
        y = 10'd480;
        tick();
    endtask

    task automatic step();
        for (int f = 0; f < MF; f++) begin
            rand_pix(int'($urandom_range(0, 3)));
            frame();
        end
    endtask

    task automatic send_dir(input int d);
        dir = 2'(d);
        dir_valid = 1'b1;
        tick();
    endtask

    task automatic probe(input string n, input int cx, input int cy, input logic [11:0] exp);
        p_tick = 1'b1;
        video_on = 1'b1;
        x = 10'(cx * 16 + int'($urandom % 16));
        y = 10'(cy * 16 + int'($urandom % 16));
        tick();
        check(n, int'(rgb), int'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_score", int'(score), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_rgb", int'(rgb), 0);
        probe("rst_head", 20, 15, HC);
        probe("rst_tail", 18, 15, BC);
        probe("rst_food", 30, 15, FC);
    endtask

    function automatic int pick_dir();
        int hx, hy, want;
        hx = m_sx[0];
        hy = m_sy[0];
        if (m_fx > hx) want = 1;
        else if (m_fx < hx) want = 3;
        else if (m_fy > hy) want = 2;
        else want = 0;
        if (want == (m_dir ^ 2)) begin
            if (m_dir == 1 || m_dir == 3) want = (hy > 0) ? 0 : 2;
            else want = (hx < 39) ? 1 : 3;
        end
        return want;
    endfunction

    // Turn aside, double back, then turn into the segment behind the old head.
    task automatic maneuver();
        int o, a;
        o = m_dir;
        if (o == 1 || o == 3) a = (m_sy[0] > 0) ? 0 : 2;
        else a = (m_sx[0] > 0) ? 3 : 1;
        send_dir(a);
        step();
        send_dir(o ^ 2);
        step();
        send_dir(a ^ 2);
        step();
        check("self_collision", int'(game_over), 1);
    endtask

    initial begin
        int mans, d;
        bit done;
        mans = 0;

        do_reset();
        p_tick = 1'b1; x = 10'd0; y = 10'd480; video_on = 1'b0;
        #1 check("frame_tick_hi", int'(frame_tick), 1);
        tick();
        #1 check("frame_tick_lo", int'(frame_tick), 0);
        probe("idle_body", 19, 15, BC);
        probe("idle_bg", 5, 5, BG);
        p_tick = 1'b1; video_on = 1'b0; x = 10'd320; y = 10'd240;
        tick();
        check("blanked", int'(rgb), 0);
        probe("idle_head", 20, 15, HC);
        p_tick = 1'b0; video_on = 1'b1; x = 10'd80; y = 10'd80;
        tick();
        check("rgb_hold", int'(rgb), int'(HC));

        send_dir(1);
        step();
        p_tick = 1'b1; video_on = 1'b1; x = 10'd336; y = 10'd240;
        tick();
        check("step1_head", int'(rgb), int'(HC));
        probe("step1_tail", 19, 15, BC);
        probe("step1_vacated", 18, 15, BG);

        send_dir(3);
        step();
        probe("reverse_ignored", 22, 15, HC);
        for (int f = 0; f < MF - 1; f++) frame();
        probe("no_step_yet", 22, 15, HC);
        frame();
        probe("counter_wrap", 23, 15, HC);

        for (int s = 0; s < 7; s++) step();
        check("ate_score", int'(score), 1);
        probe("ate_head", 30, 15, HC);
        probe("ate_len4_tail", 27, 15, BC);

        for (int s = 0; s < 9; s++) step();
        check("edge_alive", int'(game_over), 0);
        probe("edge_head", 39, 15, HC);
        step();
`ifdef SNAKE_WRAP_EN
        check("wrap_alive", int'(game_over), 0);
        probe("wrap_head", 0, 15, HC);
`else
        check("wall_over", int'(game_over), 1);
        probe("over_head", 39, 15, OC);
        probe("over_body", 38, 15, OC);
`endif
        rand_pix(10);

        for (int g = 0; g < 12 && mans < 3; g++) begin
            do_reset();
            send_dir(int'($urandom % 4));
            done = 0;
            for (int s = 0; s < 300 && m_state == 1 && !done; s++) begin
                if (m_score >= 4 || (s > 200 && m_sx.size() >= 5)) begin
                    maneuver();
                    mans++;
                    done = 1;
                end else begin
                    d = ($urandom % 10 == 0) ? int'($urandom % 4) : pick_dir();
                    if (d != m_pend) send_dir(d);
                    step();
                end
            end
            rand_pix(20);
        end
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
